// File: rtl/uart_frame_tx_if.sv
// Byte-stream interface between game-state registers, the frame packer and the UART.
// The frame packer uses the slave modport; the surrounding logic uses master.
interface uart_frame_tx_if #(
    parameter int NUM_FIELDS = 4,
    parameter int FIELD_W    = 12
);
    logic [NUM_FIELDS*FIELD_W-1:0] fields_in;
    logic                          frame_req;
    logic                          tx_done;
    logic [7:0]                    tx_data;
    logic                          tx_start;
    logic                          busy;
    logic                          frame_sent;
    logic [7:0]                    seq;

    modport master (
        output fields_in, frame_req, tx_done,
        input  tx_data, tx_start, busy, frame_sent, seq
    );

    modport slave (
        input  fields_in, frame_req, tx_done,
        output tx_data, tx_start, busy, frame_sent, seq
    );
endinterface

// File: rtl/uart_frame_tx.sv
// Packs NUM_FIELDS game-state fields into a framed byte stream:
// sync, sequence, field bytes (MSB first), XOR checksum of sequence and field bytes.
module uart_frame_tx #(
    parameter int         NUM_FIELDS = 4,
    parameter int         FIELD_W    = 12,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter bit         AUTO       = 1'b0,
    parameter int         GAP_CYCLES = 1000
) (
    input logic           clk,
    input logic           rst,
    uart_frame_tx_if.slave bus
);
    localparam int BPF   = (FIELD_W + 7) / 8;
    localparam int NB    = NUM_FIELDS * BPF;
    localparam int IDX_W = $clog2(NB + 3);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [IDX_W-1:0] CHK_IDX  = IDX_W'(NB + 2);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t                        state, state_nxt;
    logic [NUM_FIELDS*FIELD_W-1:0] snapshot;
    logic [IDX_W-1:0]              byte_idx;
    logic [7:0]                    chk;
    logic [7:0]                    tx_data_q;
    logic [7:0]                    seq_q;
    logic [7:0]                    byte_cur;
    logic                          pending;
    logic [GAP_W-1:0]              gap_cnt;
    logic                          trigger;
    logic [7:0]                    field_bytes [NB];

    assign trigger = bus.frame_req || pending || (AUTO && (gap_cnt == GAP_LAST));

    // Each field is zero-extended to whole bytes and laid out most significant byte first.
    for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_field
        logic [BPF*8-1:0] ext;
        assign ext = (BPF*8)'(snapshot[k*FIELD_W +: FIELD_W]);
        for (genvar b = 0; b < BPF; b++) begin : g_byte
            assign field_bytes[k*BPF + b] = ext[(BPF-1-b)*8 +: 8];
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path through the block infers a latch.
        byte_cur = chk;
        if (byte_idx == '0) begin
            byte_cur = SYNC_BYTE;
        end else if (byte_idx == IDX_W'(1)) begin
            byte_cur = seq_q;
        end else begin
            for (int j = 0; j < NB; j++) begin
                if (byte_idx == IDX_W'(j + 2)) byte_cur = field_bytes[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments for every flop so all state updates see pre-edge values.
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger) state_nxt = SEND;
            SEND:    state_nxt = WAIT;
            WAIT:    if (bus.tx_done) state_nxt = (byte_idx == CHK_IDX) ? DONE : SEND;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // tx_data shows the live byte during SEND and holds it until the next SEND.
    always_comb begin
        bus.tx_start   = (state == SEND);
        bus.busy       = (state == SEND) || (state == WAIT);
        bus.frame_sent = (state == DONE);
        bus.tx_data    = (state == SEND) ? byte_cur : tx_data_q;
        bus.seq        = seq_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snapshot  <= '0;
            byte_idx  <= '0;
            chk       <= '0;
            tx_data_q <= '0;
            seq_q     <= '0;
            pending   <= 1'b0;
            gap_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        snapshot <= bus.fields_in;
                        byte_idx <= '0;
                        chk      <= '0;
                        pending  <= 1'b0;
                    end
                end
                SEND: begin
                    tx_data_q <= byte_cur;
                    if (byte_idx != '0 && byte_idx != CHK_IDX) chk <= chk ^ byte_cur;
                end
                WAIT: begin
                    if (bus.tx_done) byte_idx <= byte_idx + 1'b1;
                end
                DONE: begin
                    seq_q <= seq_q + 8'd1;
                end
                default: ;
            endcase

            // One-deep queue: requests arriving outside IDLE collapse into a single flag.
            if (state != IDLE && bus.frame_req) pending <= 1'b1;

            if (!AUTO || state == DONE) begin
                gap_cnt <= '0;
            end else if (state == IDLE && gap_cnt != GAP_LAST) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: a request-driven 4x12 instance and a periodic 2x16 instance,
// each served by a UART model that answers every tx_start with tx_done ten cycles later.
module tb_uart_frame_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    logic done0, spur0, done1;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_frame_tx_if #(.NUM_FIELDS(4), .FIELD_W(12)) if0 ();
    uart_frame_tx_if #(.NUM_FIELDS(2), .FIELD_W(16)) if1 ();

    assign if0.tx_done = done0 | spur0;
    assign if1.tx_done = done1;

    uart_frame_tx #(.NUM_FIELDS(4), .FIELD_W(12), .SYNC_BYTE(8'hA5), .AUTO(1'b0), .GAP_CYCLES(1000))
        dut0 (.clk(clk), .rst(rst0), .bus(if0));
    uart_frame_tx #(.NUM_FIELDS(2), .FIELD_W(16), .SYNC_BYTE(8'hA5), .AUTO(1'b1), .GAP_CYCLES(20))
        dut1 (.clk(clk), .rst(rst1), .bus(if1));

    logic [7:0]  cap0 [$];
    int          cap_cyc0 [$];
    int          fs_cyc0 [$];
    logic [7:0]  cap1 [$];
    int          cap_cyc1 [$];
    int          fs_cyc1 [$];
    logic [31:0] fld1 [$];

    int passed = 0, failed = 0, total = 0;

    // Byte/frame monitors sample half a cycle after the active edge.
    initial forever begin
        @(negedge clk);
        if (if0.tx_start === 1'b1) begin
            cap0.push_back(if0.tx_data);
            cap_cyc0.push_back(cyc);
        end
        if (if0.frame_sent === 1'b1) fs_cyc0.push_back(cyc);
    end

    initial forever begin
        @(negedge clk);
        if (if1.tx_start === 1'b1) begin
            if (cap1.size() % 7 == 0) fld1.push_back(if1.fields_in);
            cap1.push_back(if1.tx_data);
            cap_cyc1.push_back(cyc);
        end
        if (if1.frame_sent === 1'b1) fs_cyc1.push_back(cyc);
    end

    initial begin : uart0
        int cnt;
        cnt   = 0;
        done0 = 1'b0;
        forever begin
            @(negedge clk);
            done0 = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) done0 = 1'b1;
            end
            if (if0.tx_start === 1'b1) cnt = 10;
        end
    end

    initial begin : uart1
        int cnt;
        cnt   = 0;
        done1 = 1'b0;
        forever begin
            @(negedge clk);
            done1 = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) done1 = 1'b1;
            end
            if (if1.tx_start === 1'b1) cnt = 10;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame built straight from the frame rules, first byte in the top occupied bits.
    function automatic logic [127:0] model_frame(input int nf, input int fw, input logic [7:0] sq,
                                                 input logic [255:0] flds);
        int           bpf;
        int           f;
        logic [127:0] acc;
        logic [7:0]   c, b;
        bpf = (fw + 7) / 8;
        acc = 128'(8'hA5);
        acc = (acc << 8) | 128'(sq);
        c   = sq;
        for (int k = 0; k < nf; k++) begin
            f = int'((flds >> (k * fw)) & ((256'd1 << fw) - 256'd1));
            for (int i = bpf - 1; i >= 0; i--) begin
                b   = 8'((f >> (8 * i)) & 255);
                acc = (acc << 8) | 128'(b);
                c   = c ^ b;
            end
        end
        acc = (acc << 8) | 128'(c);
        return acc;
    endfunction

    function automatic logic [127:0] pack(input logic [7:0] q[$], input int s, input int n);
        logic [127:0] acc;
        acc = '0;
        for (int i = 0; i < n; i++) acc = (acc << 8) | 128'(q[s + i]);
        return acc;
    endfunction

    task automatic pulse_req0(output int req_cyc);
        @(negedge clk);
        if0.frame_req = 1'b1;
        req_cyc = cyc;
        @(negedge clk);
        if0.frame_req = 1'b0;
    endtask

    task automatic wait_sent0(input string tag);
        int n;
        n = 0;
        while (if0.frame_sent !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 128'(n < 3000), 128'(1));
    endtask

    task automatic wait_bytes0(input int target, input string tag);
        int n;
        n = 0;
        while (cap0.size() < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 128'(n < 3000), 128'(1));
    endtask

    logic [47:0] f0;
    logic [47:0] f_orig;
    logic [7:0]  exp_seq0;
    int          s, rc, nfs, n;

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        spur0 = 1'b0;
        if0.frame_req = 1'b0;
        if1.frame_req = 1'b0;
        f_orig = {12'hABC, 12'h789, 12'h456, 12'h123};
        if0.fields_in = f_orig;
        if1.fields_in = {16'h0001, 16'hBEEF};
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_data", 128'(if0.tx_data), 128'(0));
        check("rst_tx_start", 128'(if0.tx_start), 128'(0));
        check("rst_busy", 128'(if0.busy), 128'(0));
        check("rst_frame_sent", 128'(if0.frame_sent), 128'(0));
        check("rst_seq", 128'(if0.seq), 128'(0));
        @(negedge clk);
        rst0 = 1'b1;
        rst1 = 1'b1;
        exp_seq0 = 8'h00;

        // Frame 1: fixed fields, inputs change after the third byte.
        s = cap0.size();
        pulse_req0(rc);
        check("lat_tx_start", 128'(if0.tx_start), 128'(1));
        check("lat_busy", 128'(if0.busy), 128'(1));
        check("first_byte", 128'(if0.tx_data), 128'(8'hA5));
        wait_bytes0(s + 3, "wait_byte3");
        if0.fields_in = {4{12'hFFF}};
        wait_sent0("wait_frame1");
        check("lat_cycles", 128'(cap_cyc0[s] - rc), 128'(1));
        @(negedge clk);
        check("frame1", pack(cap0, s, 11), model_frame(4, 12, exp_seq0, 256'(f_orig)));
        check("frame1_chk", 128'(cap0[s + 10]), 128'(8'h48));
        check("frame1_count", 128'(fs_cyc0.size()), 128'(1));
        check("frame1_seq", 128'(if0.seq), 128'(8'h01));
        exp_seq0++;

        // Frame 2: the all-ones fields latched at this request.
        s = cap0.size();
        pulse_req0(rc);
        wait_sent0("wait_frame2");
        @(negedge clk);
        check("frame2", pack(cap0, s, 11), model_frame(4, 12, exp_seq0, 256'({4{12'hFFF}})));
        check("frame2_chk", 128'(cap0[s + 10]), 128'(8'h01));
        exp_seq0++;

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) f0[k*12 +: 12] = 12'($urandom);
            if0.fields_in = f0;
            s = cap0.size();
            pulse_req0(rc);
            wait_sent0("wait_rand");
            @(negedge clk);
            check("rand_frame", pack(cap0, s, 11), model_frame(4, 12, exp_seq0, 256'(f0)));
            exp_seq0++;
        end

        // Three requests during one frame queue exactly one more.
        for (int k = 0; k < 4; k++) f0[k*12 +: 12] = 12'($urandom);
        if0.fields_in = f0;
        s = cap0.size();
        nfs = fs_cyc0.size();
        pulse_req0(rc);
        for (int i = 0; i < 3; i++) begin
            repeat (20) @(negedge clk);
            pulse_req0(rc);
        end
        wait_sent0("pend_frame_a");
        @(negedge clk);
        wait_sent0("pend_frame_b");
        repeat (200) @(negedge clk);
        check("pend_count", 128'(fs_cyc0.size() - nfs), 128'(2));
        check("pend_frame_a", pack(cap0, s, 11), model_frame(4, 12, exp_seq0, 256'(f0)));
        check("pend_frame_b", pack(cap0, s + 11, 11), model_frame(4, 12, exp_seq0 + 8'd1, 256'(f0)));
        check("pend_gap", 128'(cap_cyc0[s + 11] - fs_cyc0[nfs]), 128'(2));
        exp_seq0 += 8'd2;

        // A request landing in the DONE cycle is queued.
        for (int k = 0; k < 4; k++) f0[k*12 +: 12] = 12'($urandom);
        if0.fields_in = f0;
        s = cap0.size();
        nfs = fs_cyc0.size();
        pulse_req0(rc);
        wait_sent0("done_frame_a");
        if0.frame_req = 1'b1;
        @(negedge clk);
        if0.frame_req = 1'b0;
        wait_sent0("done_frame_b");
        repeat (200) @(negedge clk);
        check("done_count", 128'(fs_cyc0.size() - nfs), 128'(2));
        check("done_frame_b", pack(cap0, s + 11, 11), model_frame(4, 12, exp_seq0 + 8'd1, 256'(f0)));
        check("done_gap", 128'(cap_cyc0[s + 11] - fs_cyc0[nfs]), 128'(2));
        exp_seq0 += 8'd2;

        // Reset while waiting on the fifth byte.
        for (int k = 0; k < 4; k++) f0[k*12 +: 12] = 12'($urandom);
        if0.fields_in = f0;
        s = cap0.size();
        pulse_req0(rc);
        wait_bytes0(s + 5, "rst_byte5");
        repeat (3) @(negedge clk);
        check("rst_pre_seq", 128'(if0.seq), 128'(exp_seq0));
        check("rst_pre_busy", 128'(if0.busy), 128'(1));
        #2;
        rst0 = 1'b0;
        #1;
        check("arst_tx_start", 128'(if0.tx_start), 128'(0));
        check("arst_busy", 128'(if0.busy), 128'(0));
        check("arst_tx_data", 128'(if0.tx_data), 128'(0));
        check("arst_frame_sent", 128'(if0.frame_sent), 128'(0));
        check("arst_seq", 128'(if0.seq), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst0 = 1'b1;
        repeat (5) @(negedge clk);
        spur0 = 1'b1;
        @(negedge clk);
        spur0 = 1'b0;
        repeat (25) @(negedge clk);
        check("post_rst_no_start", 128'(cap0.size()), 128'(s + 5));
        check("post_rst_busy", 128'(if0.busy), 128'(0));
        exp_seq0 = 8'h00;
        for (int k = 0; k < 4; k++) f0[k*12 +: 12] = 12'($urandom);
        if0.fields_in = f0;
        s = cap0.size();
        pulse_req0(rc);
        wait_sent0("wait_post_rst");
        @(negedge clk);
        check("post_rst_frame", pack(cap0, s, 11), model_frame(4, 12, exp_seq0, 256'(f0)));
        check("post_rst_seq", 128'(if0.seq), 128'(8'h01));

        // Periodic instance: let 257 frames go by, changing fields after each DONE.
        n = 0;
        while (fs_cyc1.size() < 257 && n < 40000) begin
            @(negedge clk);
            n++;
            if (if1.frame_sent === 1'b1 && fs_cyc1.size() >= 2) if1.fields_in = $urandom;
        end
        check("auto_wait", 128'(fs_cyc1.size() >= 257), 128'(1));
        repeat (2) @(negedge clk);
        check("auto_seq", 128'(if1.seq), 128'(8'(fs_cyc1.size())));
        check("auto_frame0_chk", 128'(cap1[6]), 128'(8'h50));
        for (int i = 0; i < 257; i++) begin
            check("auto_frame", pack(cap1, 7 * i, 7), model_frame(2, 16, 8'(i), 256'(fld1[i])));
        end
        check("auto_gap0", 128'(cap_cyc1[7] - fs_cyc1[0]), 128'(21));
        check("auto_gap1", 128'(cap_cyc1[14] - fs_cyc1[1]), 128'(21));
        check("auto_gap2", 128'(cap_cyc1[21] - fs_cyc1[2]), 128'(21));
        check("auto_gap255", 128'(cap_cyc1[7 * 256] - fs_cyc1[255]), 128'(21));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
Parametrised successor to the fixed two-field UART transmit multiplexer. Packs NUM_FIELDS game-state fields of FIELD_W bits into a framed, sequenced, checksummed byte stream. Frame layout: sync, sequence, field bytes, checksum. Sits between game-logic registers (player/ball positions, scores, flags) and the byte-level UART transmitter. Supports on-request and periodic auto-send modes, and snapshots all fields atomically per frame.

Parameters:
NUM_FIELDS, 4, number of fields per frame (1..16)
FIELD_W, 12, bits per field (1..16); BPF = (FIELD_W+7)/8 bytes per field
SYNC_BYTE, 8'hA5, first byte of every frame
AUTO, 0, 1 = periodic frames every GAP_CYCLES after previous frame end; 0 = request only
GAP_CYCLES, 1000, idle cycles between auto frames (>=1)

Ports:
clk  in  1  system clock (pclk domain, 65 MHz)
rst  in  1  asynchronous, active-low reset
fields_in  in  NUM_FIELDS*FIELD_W  field k at bits [k*FIELD_W +: FIELD_W]; field 0 sent first
frame_req  in  1  single-cycle request to send one frame
tx_done  in  1  one-cycle pulse from UART: current byte finished
tx_data  out  8  byte presented to UART
tx_start  out  1  one-cycle pulse: UART loads tx_data
busy  out  1  high from frame start to frame end
frame_sent  out  1  one-cycle pulse after checksum byte's tx_done
seq  out  8  sequence number of next frame

Behaviour:
- Reset (rst low, async): state IDLE; tx_data=0, tx_start=0, busy=0, frame_sent=0, seq=0; pending and gap counter cleared; snapshot cleared.
- Byte order per frame: SYNC_BYTE, seq, for each field k=0..NUM_FIELDS-1 its BPF bytes MSB first (field zero-extended to BPF*8 bits), then CHK. CHK = XOR of seq and all field bytes (SYNC excluded). Total bytes = 3 + NUM_FIELDS*BPF.
- Trigger: frame_req, or (AUTO=1 and gap counter == GAP_CYCLES-1).
- States:
  - IDLE: on trigger, register fields_in into snapshot, clear byte index and running checksum, set busy; next state SEND. Latency: tx_start rises on the cycle after the trigger cycle.
  - SEND: tx_start=1 for exactly one cycle, tx_data = current byte (held stable until the next SEND). Fold the byte into the checksum (except SYNC and CHK). Next state WAIT.
  - WAIT: on tx_done, advance byte index. If the byte sent was CHK, go DONE; else go SEND.
  - DONE: frame_sent=1 for one cycle, busy=0, seq increments (8-bit wrap FF->00), gap counter cleared. Next state IDLE.
- Pending request: frame_req while busy sets a one-deep pending flag; further requests are absorbed. In IDLE, pending acts as the trigger and is then cleared. Result: at most one extra frame is queued.
- Auto mode: the gap counter increments only in IDLE and saturates at GAP_CYCLES-1. With AUTO=0 the counter is held at 0.
- Simultaneous events: frame_req and auto trigger in the same cycle produce one frame. frame_req in the DONE cycle sets pending.
- tx_done outside WAIT is ignored. fields_in changes during a frame do not affect it; only the snapshot is sent.
- Reset mid-frame aborts immediately with no further tx_start; seq returns to 0.

Test Plan:
- Default params, fields 0x123,0x456,0x789,0xABC, frame_req pulse, UART model returns tx_done 10 cycles after each tx_start -> bytes A5 00 01 23 04 56 07 89 0A BC 48 (11 bytes); frame_sent once; seq=01; tx_start first seen 1 cycle after frame_req.
- Change fields_in to all 0xFFF after the 3rd byte -> remaining bytes unchanged from the snapshot; next frame sends 0F FF x4 with seq 01 and CHK = 01 (01 XOR eight bytes that cancel in pairs).
- Three frame_req pulses during one frame -> exactly two frames total; second starts 1 cycle after first frame_sent+1 (IDLE pass).
- AUTO=1, GAP_CYCLES=20, no requests -> frame starts every 20 idle cycles after each DONE; seq increments 00,01,02; 256 frames wrap seq to 00.
- NUM_FIELDS=2, FIELD_W=16, fields 0xBEEF,0x0001 -> A5 00 BE EF 00 01 CHK=0x50.
- rst low during WAIT of byte 5 -> outputs zero asynchronously; after release no tx_start until a new request; next frame seq=00; spurious tx_done in IDLE ignored.
